// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions for the master interface FSM: state encoding,
// read/write encoding and active-low enable levels.
package bus_master_if_pkg;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } bus_if_state_e;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_master_if.sv
// Per-master bus interface: core strobe -> bus_req_/grnt_ handshake -> access.
// Optional slave-ready timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_as_,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic              core_hold,
    input  logic              core_flush,
    output logic              core_busy,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    bus_if_state_e     state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt, bus_addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt, bus_wr_data_nxt, core_rd_data_nxt;
    logic              rw_q, rw_nxt, bus_rw_nxt;
    logic              bus_req_nxt, bus_as_nxt, core_busy_nxt, core_err_nxt;
    logic              timeout;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;

    // Counter holds the number of completed ACCESS cycles before this one.
    assign timeout = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_nxt = tmo_cnt;
        if (state == BUS_IF_STATE_REQ && bus_grnt_ == ENABLE_)
            tmo_cnt_nxt = '0;
        else if (state == BUS_IF_STATE_ACCESS)
            tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_cnt <= '0;
        else       tmo_cnt <= tmo_cnt_nxt;
    end
`else
    // Timeout length is meaningless when the counter is not built.
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BUS_IF_STATE_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= READ;
            bus_req_     <= DISABLE_;
            bus_as_      <= DISABLE_;
            bus_rw       <= READ;
            bus_addr     <= '0;
            bus_wr_data  <= '0;
            core_rd_data <= '0;
            core_busy    <= 1'b0;
            core_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr_q       <= addr_nxt;
            wdata_q      <= wdata_nxt;
            rw_q         <= rw_nxt;
            bus_req_     <= bus_req_nxt;
            bus_as_      <= bus_as_nxt;
            bus_rw       <= bus_rw_nxt;
            bus_addr     <= bus_addr_nxt;
            bus_wr_data  <= bus_wr_data_nxt;
            core_rd_data <= core_rd_data_nxt;
            core_busy    <= core_busy_nxt;
            core_err     <= core_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BUS_IF_STATE_IDLE:   if (core_as_ == ENABLE_ && !core_flush) state_nxt = BUS_IF_STATE_REQ;
            BUS_IF_STATE_REQ:    if (bus_grnt_ == ENABLE_) state_nxt = BUS_IF_STATE_ACCESS;
            BUS_IF_STATE_ACCESS: if (bus_rdy_ == ENABLE_ || timeout) state_nxt = BUS_IF_STATE_STALL;
            BUS_IF_STATE_STALL:  if (!core_hold) state_nxt = BUS_IF_STATE_IDLE;
            default:             state_nxt = BUS_IF_STATE_IDLE;
        endcase
    end

    always_comb begin
        addr_nxt         = addr_q;
        wdata_nxt        = wdata_q;
        rw_nxt           = rw_q;
        bus_req_nxt      = bus_req_;
        bus_as_nxt       = bus_as_;
        bus_rw_nxt       = bus_rw;
        bus_addr_nxt     = bus_addr;
        bus_wr_data_nxt  = bus_wr_data;
        core_rd_data_nxt = core_rd_data;
        core_busy_nxt    = core_busy;
        core_err_nxt     = core_err;
        case (state)
            BUS_IF_STATE_IDLE: begin
                if (core_as_ == ENABLE_ && !core_flush) begin
                    addr_nxt      = core_addr;
                    wdata_nxt     = core_wr_data;
                    rw_nxt        = core_rw;
                    bus_req_nxt   = ENABLE_;
                    core_busy_nxt = 1'b1;
                    core_err_nxt  = 1'b0;
                end
            end
            BUS_IF_STATE_REQ: begin
                if (bus_grnt_ == ENABLE_) begin
                    bus_as_nxt      = ENABLE_;
                    bus_addr_nxt    = addr_q;
                    bus_rw_nxt      = rw_q;
                    bus_wr_data_nxt = wdata_q;
                end
            end
            BUS_IF_STATE_ACCESS: begin
                bus_as_nxt = DISABLE_;
                if (bus_rdy_ == ENABLE_) begin
                    bus_req_nxt   = DISABLE_;
                    core_busy_nxt = 1'b0;
                    if (rw_q == READ) core_rd_data_nxt = bus_rd_data;
                end else if (timeout) begin
                    bus_req_nxt   = DISABLE_;
                    core_busy_nxt = 1'b0;
                    core_err_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed self-checking bench for bus_master_if; define BUS_MASTER_TIMEOUT_EN
// on both RTL and bench to exercise the timeout path.
module tb_bus_master_if;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_as_, core_rw, core_hold, core_flush;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_busy, core_err;
    logic [DATA_W-1:0] core_rd_data;
    logic              bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data, bus_rd_data;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset),
        .core_as_(core_as_), .core_rw(core_rw), .core_addr(core_addr),
        .core_wr_data(core_wr_data), .core_hold(core_hold), .core_flush(core_flush),
        .core_busy(core_busy), .core_rd_data(core_rd_data), .core_err(core_err),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; core_as_ = 1'b1; core_rw = 1'b1; core_addr = '0; core_wr_data = '0;
        core_hold = 1'b0; core_flush = 1'b0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
        tick(); tick();
        check("rst_req_", bus_req_, 1);
        check("rst_as_", bus_as_, 1);
        check("rst_rw", bus_rw, 1);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wr_data, 0);
        check("rst_rdata", core_rd_data, 0);
        check("rst_busy", core_busy, 0);
        check("rst_err", core_err, 0);
        reset = 1'b0;
        tick();

        // Read, immediate grant, ready one cycle after the address strobe.
        core_as_ = 1'b0; core_rw = 1'b1; core_addr = 30'h0000_0100; bus_grnt_ = 1'b0;
        tick();
        core_as_ = 1'b1;
        check("rd_c1_req_", bus_req_, 0);
        check("rd_c1_busy", core_busy, 1);
        check("rd_c1_as_", bus_as_, 1);
        tick();
        check("rd_c2_as_", bus_as_, 0);
        check("rd_c2_addr", bus_addr, 30'h100);
        check("rd_c2_rw", bus_rw, 1);
        tick();
        check("rd_c3_as_", bus_as_, 1);
        check("rd_c3_busy", core_busy, 1);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        tick();
        bus_rdy_ = 1'b1; bus_rd_data = '0; bus_grnt_ = 1'b1;
        check("rd_c4_rdata", core_rd_data, 32'hDEAD_BEEF);
        check("rd_c4_busy", core_busy, 0);
        check("rd_c4_req_", bus_req_, 1);
        tick();

        // Write, grant arrives after five cycles of REQ; ready in REQ ignored.
        core_as_ = 1'b0; core_rw = 1'b0; core_addr = 30'h2A; core_wr_data = 32'h1234_5678;
        for (int c = 1; c <= 6; c++) begin
            tick();
            core_as_ = 1'b1;
            check("wr_req_as_", bus_as_, 1);
            check("wr_req_busy", core_busy, 1);
            check("wr_req_req_", bus_req_, 0);
            bus_rdy_ = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            bus_rd_data = (c == 2 || c == 3) ? 32'h0000_0BAD : '0;
            if (c == 6) bus_grnt_ = 1'b0;
        end
        tick();
        check("wr_c7_as_", bus_as_, 0);
        check("wr_c7_rw", bus_rw, 0);
        check("wr_c7_wdata", bus_wr_data, 32'h1234_5678);
        check("wr_c7_addr", bus_addr, 30'h2A);
        bus_grnt_ = 1'b1;
        tick();
        check("wr_c8_as_", bus_as_, 1);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFF_FFFF;
        tick();
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        check("wr_c9_busy", core_busy, 0);
        check("wr_c9_rdata", core_rd_data, 32'hDEAD_BEEF);
        tick();

        // Hold in STALL blocks re-issue of a still-asserted strobe.
        core_as_ = 1'b0; core_rw = 1'b1; core_addr = 30'h3; bus_grnt_ = 1'b0;
        tick();
        core_as_ = 1'b1;
        tick();
        tick();
        bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D; core_hold = 1'b1;
        tick();
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; core_as_ = 1'b0;
        check("hold_rdata", core_rd_data, 32'hCAFE_F00D);
        check("hold_busy", core_busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_req_", bus_req_, 1);
            tick();
        end
        core_hold = 1'b0;
        check("hold_rel_req_", bus_req_, 1);
        tick();
        check("hold_idle_req_", bus_req_, 1);
        check("hold_idle_busy", core_busy, 0);
        tick();
        check("hold_reissue_req_", bus_req_, 0);
        check("hold_reissue_busy", core_busy, 1);
        core_as_ = 1'b1; bus_grnt_ = 1'b0;
        tick();
        tick();
        bus_rdy_ = 1'b0; bus_rd_data = 32'h0000_0000;
        tick();
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        check("hold_done_busy", core_busy, 0);
        check("hold_done_rdata", core_rd_data, 0);
        tick();

        // Flush suppresses a new request in IDLE.
        core_as_ = 1'b0; core_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_req_", bus_req_, 1);
            check("flush_busy", core_busy, 0);
        end
        core_as_ = 1'b1; core_flush = 1'b0;
        tick();

        // Reset during ACCESS abandons the access with no data returned.
        core_as_ = 1'b0; core_rw = 1'b1; core_addr = 30'h5; bus_grnt_ = 1'b0;
        tick();
        core_as_ = 1'b1;
        tick();
        check("rstacc_as_", bus_as_, 0);
        tick();
        reset = 1'b1; bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h5555_5555;
        tick();
        reset = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = '0;
        check("rstacc_req_", bus_req_, 1);
        check("rstacc_busy", core_busy, 0);
        check("rstacc_as_hi", bus_as_, 1);
        check("rstacc_rdata", core_rd_data, 0);
        tick();
        check("rstacc_idle_req_", bus_req_, 1);

        // Slave never answers.
        core_as_ = 1'b0; core_rw = 1'b1; core_addr = 30'h7; bus_grnt_ = 1'b0;
        tick();
        core_as_ = 1'b1;
        tick();
        bus_grnt_ = 1'b1;
        tick();
        tick();
        tick();
        check("tmo_c5_busy", core_busy, 1);
        check("tmo_c5_err", core_err, 0);
        tick();
`ifdef BUS_MASTER_TIMEOUT_EN
        check("tmo_err", core_err, 1);
        check("tmo_busy", core_busy, 0);
        check("tmo_req_", bus_req_, 1);
        check("tmo_rdata", core_rd_data, 0);
        tick();
        check("tmo_err_held", core_err, 1);
        core_as_ = 1'b0; core_rw = 1'b0; core_addr = 30'h8; bus_grnt_ = 1'b0;
        tick();
        core_as_ = 1'b1;
        check("tmo_clr_err", core_err, 0);
        check("tmo_clr_busy", core_busy, 1);
        tick();
        bus_rdy_ = 1'b0;
        tick();
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        check("tmo_next_busy", core_busy, 0);
        check("tmo_next_err", core_err, 0);
        tick();
`else
        check("notmo_busy", core_busy, 1);
        check("notmo_err", core_err, 0);
        repeat (10) tick();
        check("notmo_long_busy", core_busy, 1);
        check("notmo_long_err", core_err, 0);
        check("notmo_long_req_", bus_req_, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_0001;
        tick();
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        check("notmo_done_busy", core_busy, 0);
        check("notmo_done_rdata", core_rd_data, 32'hA5A5_0001);
        check("notmo_done_err", core_err, 0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
